// File: rtl/paddle_drawer.sv
// Paddle strip renderer: on a start request it rasterises a PAD_H-row strip
// across the full screen width, one pixel per clock, painting the paddle in
// FG_COLOR around a latched centre column and everything else in BG_COLOR.
// Between scans the internal key-driven paddle position is updated.
module paddle_drawer #(
    parameter int          SCREEN_W = 120,
    parameter int          PAD_W    = 7,
    parameter int          PAD_H    = 3,
    parameter int          ROW_Y    = 112,
    parameter logic [2:0]  FG_COLOR = 3'b001,
    parameter logic [2:0]  BG_COLOR = 3'b000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       erase_only,
    input  logic       use_ext,
    input  logic [7:0] ext_pos,
    input  logic       move_left,
    input  logic       move_right,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] color,
    output logic       plot,
    output logic       busy,
    output logic       done,
    output logic [7:0] cur_pos
);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    localparam int                  ROW_BITS = (PAD_H > 1) ? $clog2(PAD_H) : 1;
    localparam logic [7:0]          MAX_POS  = 8'(SCREEN_W - 1);
    localparam logic [7:0]          HOME_POS = 8'((SCREEN_W - 1) / 2);
    localparam logic [ROW_BITS-1:0] LAST_ROW = ROW_BITS'(PAD_H - 1);
    localparam logic [8:0]          HALF9    = 9'(PAD_W / 2);
    localparam logic [8:0]          WIDTH9   = 9'(SCREEN_W);
    localparam logic [6:0]          ROW_Y7   = 7'(ROW_Y);

    state_t              state;
    logic [7:0]          col;
    logic [ROW_BITS-1:0] row;
    logic [7:0]          centre;
    logic                erase_lat;

    logic [7:0] sel_pos;
    logic [7:0] clamp_pos;
    logic       in_paddle;
    logic [2:0] pix_color;
    logic       last_pix;

    // Centre selection with clamping, and paddle hit test done in 9 bits so
    // neither col+HALF nor centre+HALF can wrap near the screen edges.
    always_comb begin
        sel_pos   = use_ext ? ext_pos : cur_pos;
        clamp_pos = ({1'b0, sel_pos} >= WIDTH9) ? MAX_POS : sel_pos;
        in_paddle = (({1'b0, col} + HALF9) >= {1'b0, centre}) &&
                    ({1'b0, col} <= ({1'b0, centre} + HALF9));
        pix_color = (!erase_lat && in_paddle) ? FG_COLOR : BG_COLOR;
        last_pix  = (col == MAX_POS) && (row == LAST_ROW);
    end

    // Scan FSM with registered pixel outputs and the key-driven position.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state     <= IDLE;
            col       <= '0;
            row       <= '0;
            centre    <= '0;
            erase_lat <= 1'b0;
            x         <= '0;
            y         <= '0;
            color     <= '0;
            plot      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            cur_pos   <= HOME_POS;
        end else begin
            case (state)
                IDLE: begin
                    plot <= 1'b0;
                    done <= 1'b0;
                    if (start) begin
                        centre    <= clamp_pos;
                        erase_lat <= erase_only;
                        col       <= '0;
                        row       <= '0;
                        busy      <= 1'b1;
                        state     <= SCAN;
                    end else begin
                        // Opposing keys cancel; both ends saturate.
                        case ({move_left, move_right})
                            2'b01: if (cur_pos != MAX_POS) cur_pos <= cur_pos + 8'd1;
                            2'b10: if (cur_pos != 8'd0)    cur_pos <= cur_pos - 8'd1;
                            default: ;
                        endcase
                    end
                end
                SCAN: begin
                    plot  <= 1'b1;
                    x     <= col;
                    y     <= ROW_Y7 + 7'(row);
                    color <= pix_color;
                    if (last_pix) begin
                        state <= DONE;
                    end else if (row == LAST_ROW) begin
                        row <= '0;
                        col <= col + 8'd1;
                    end else begin
                        row <= row + ROW_BITS'(1);
                    end
                end
                DONE: begin
                    plot  <= 1'b0;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    col   <= '0;
                    row   <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_paddle_drawer.sv
// Self-checking bench for paddle_drawer at default parameters.
module tb_paddle_drawer;

    localparam int W    = 120;
    localparam int H    = 3;
    localparam int HALF = 3;
    localparam int N    = W * H;
    localparam int ROWY = 112;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       erase_only = 1'b0;
    logic       use_ext = 1'b0;
    logic [7:0] ext_pos = 8'd0;
    logic       move_left = 1'b0;
    logic       move_right = 1'b0;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] color;
    logic       plot;
    logic       busy;
    logic       done;
    logic [7:0] cur_pos;

    int errors = 0;
    int checks = 0;

    logic [7:0] qx[$];
    logic [6:0] qy[$];
    logic [2:0] qc[$];
    int nplot, first_plot, last_plot, done_at, done_cnt;
    logic busy_mid;

    paddle_drawer dut (
        .clock(clock), .reset(reset), .start(start), .erase_only(erase_only),
        .use_ext(use_ext), .ext_pos(ext_pos), .move_left(move_left),
        .move_right(move_right), .x(x), .y(y), .color(color), .plot(plot),
        .busy(busy), .done(done), .cur_pos(cur_pos)
    );

    always #5 clock = ~clock;

    // Reference colour: paddle covers columns within HALF of the centre.
    function automatic logic [2:0] ref_color(int col, int pos, bit er);
        int d;
        if (er) return 3'b000;
        d = col - pos;
        if (d < 0) d = -d;
        return (d <= HALF) ? 3'b001 : 3'b000;
    endfunction

    // Number of captured pixels deviating from the expected raster.
    function automatic int scan_errs(int pos, bit er);
        int e = 0;
        if (qx.size() != N) return N + 1;
        for (int i = 0; i < N; i++) begin
            if (qx[i] !== 8'(i / H) || qy[i] !== 7'(ROWY + i % H) ||
                qc[i] !== ref_color(i / H, pos, er)) e++;
        end
        return e;
    endfunction

    function automatic int fg_count(int min_x);
        int n = 0;
        for (int i = 0; i < qc.size(); i++)
            if (qc[i] === 3'b001 && int'(qx[i]) >= min_x) n++;
        return n;
    endfunction

    // Pulse start and record every plotted pixel plus done timing.
    task automatic capture(input int mid_start, input bit hold_left, input bit jitter);
        qx.delete(); qy.delete(); qc.delete();
        nplot = 0; first_plot = -1; last_plot = -1; done_at = -1; done_cnt = 0;
        busy_mid = 1'b0;
        start = 1'b1;
        move_left = hold_left;
        for (int c = 0; c <= N + 12; c++) begin
            @(posedge clock); #1;
            if (c == 0) start = 1'b0;
            if (c == mid_start) start = 1'b1;
            if (c == mid_start + 1) start = 1'b0;
            if (jitter && c < N) begin
                ext_pos = 8'($urandom);
                use_ext = 1'($urandom);
            end
            if (plot) begin
                qx.push_back(x); qy.push_back(y); qc.push_back(color);
                nplot++;
                if (first_plot < 0) first_plot = c;
                last_plot = c;
            end
            if (done) begin
                done_cnt++;
                if (done_at < 0) done_at = c;
                move_left = 1'b0;
            end
            if (c == N / 2) busy_mid = busy;
        end
        move_left = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        checks++;
        if ({x, y, color, plot, busy, done} !== 21'd0) begin
            errors++;
            $display("FAIL reset_outputs: got x=%0d y=%0d color=%0d plot=%0b busy=%0b done=%0b, want all 0",
                     x, y, color, plot, busy, done);
        end
        checks++;
        if (cur_pos !== 8'd59) begin
            errors++;
            $display("FAIL reset_cur_pos: got %0d want 59", cur_pos);
        end
        reset = 1'b1;
        @(posedge clock); #1;
    endtask

    task automatic test_centred;
        int e;
        use_ext = 1'b1; ext_pos = 8'd60; erase_only = 1'b0;
        capture(-1, 1'b0, 1'b0);
        e = scan_errs(60, 1'b0);
        checks++;
        if (nplot !== N) begin errors++; $display("FAIL centred_count: got %0d want %0d", nplot, N); end
        checks++;
        if (first_plot !== 1 || last_plot !== N) begin
            errors++; $display("FAIL centred_window: got %0d..%0d want 1..%0d", first_plot, last_plot, N);
        end
        checks++;
        if (done_at !== N + 1 || done_cnt !== 1) begin
            errors++; $display("FAIL centred_done: got at %0d count %0d want at %0d count 1", done_at, done_cnt, N + 1);
        end
        checks++;
        if (e !== 0) begin errors++; $display("FAIL centred_pixels: got %0d bad pixels want 0", e); end
        checks++;
        if (fg_count(0) !== 21) begin errors++; $display("FAIL centred_fg: got %0d want 21", fg_count(0)); end
        checks++;
        if (busy_mid !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL centred_busy: got mid=%0b end=%0b want 1/0", busy_mid, busy);
        end
        checks++;
        if (plot !== 1'b0 || done !== 1'b0 || x !== 8'd119 || y !== 7'd114) begin
            errors++; $display("FAIL idle_hold: got plot=%0b done=%0b x=%0d y=%0d want 0 0 119 114", plot, done, x, y);
        end
    endtask

    task automatic test_edge_clamp;
        int e;
        use_ext = 1'b1; ext_pos = 8'd0;
        capture(-1, 1'b0, 1'b0);
        e = scan_errs(0, 1'b0);
        checks++;
        if (e !== 0 || fg_count(0) !== 12) begin
            errors++; $display("FAIL edge_left: got %0d bad, %0d fg want 0 bad, 12 fg", e, fg_count(0));
        end
        checks++;
        if (fg_count(117) !== 0) begin errors++; $display("FAIL edge_left_wrap: got %0d fg at x>=117 want 0", fg_count(117)); end
        ext_pos = 8'd200;
        capture(-1, 1'b0, 1'b0);
        e = scan_errs(119, 1'b0);
        checks++;
        if (e !== 0 || fg_count(116) !== 12 || fg_count(0) !== 12) begin
            errors++; $display("FAIL clamp_200: got %0d bad, %0d fg want 0 bad, 12 fg at 116..119", e, fg_count(0));
        end
        ext_pos = 8'd255;
        capture(-1, 1'b0, 1'b0);
        e = scan_errs(119, 1'b0);
        checks++;
        if (e !== 0) begin errors++; $display("FAIL clamp_255: got %0d bad pixels want 0", e); end
    endtask

    task automatic test_keys;
        int e;
        use_ext = 1'b0;
        move_right = 1'b1;
        repeat (70) @(posedge clock);
        #1; move_right = 1'b0;
        checks++;
        if (cur_pos !== 8'd119) begin errors++; $display("FAIL keys_right_sat: got %0d want 119", cur_pos); end
        move_left = 1'b1; move_right = 1'b1;
        repeat (5) @(posedge clock);
        #1; move_right = 1'b0;
        checks++;
        if (cur_pos !== 8'd119) begin errors++; $display("FAIL keys_both: got %0d want 119", cur_pos); end
        repeat (4) @(posedge clock);
        #1; move_left = 1'b0;
        checks++;
        if (cur_pos !== 8'd115) begin errors++; $display("FAIL keys_left: got %0d want 115", cur_pos); end
        capture(-1, 1'b1, 1'b0);
        e = scan_errs(115, 1'b0);
        checks++;
        if (cur_pos !== 8'd115) begin errors++; $display("FAIL keys_scan_left: got %0d want 115", cur_pos); end
        checks++;
        if (e !== 0) begin errors++; $display("FAIL keys_internal_draw: got %0d bad pixels want 0", e); end
        move_left = 1'b1;
        repeat (130) @(posedge clock);
        #1; move_left = 1'b0;
        checks++;
        if (cur_pos !== 8'd0) begin errors++; $display("FAIL keys_left_sat: got %0d want 0", cur_pos); end
    endtask

    task automatic test_erase_ignore;
        int e;
        use_ext = 1'b1; ext_pos = 8'd60; erase_only = 1'b1;
        capture(-1, 1'b0, 1'b0);
        erase_only = 1'b0;
        e = scan_errs(60, 1'b1);
        checks++;
        if (e !== 0 || fg_count(0) !== 0) begin errors++; $display("FAIL erase: got %0d bad, %0d fg want 0, 0", e, fg_count(0)); end
        capture(50, 1'b0, 1'b0);
        checks++;
        if (nplot !== N || done_cnt !== 1) begin
            errors++; $display("FAIL ignore_start: got %0d plots %0d done want %0d plots 1 done", nplot, done_cnt, N);
        end
    endtask

    task automatic test_midscan_reset;
        int cnt = 0;
        int extra_plot = 0;
        int extra_done = 0;
        int e;
        use_ext = 1'b1; ext_pos = 8'd30;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        for (int c = 0; c < 200 && cnt < 100; c++) begin
            @(posedge clock); #1;
            if (plot) cnt++;
        end
        checks++;
        if (cnt !== 100) begin errors++; $display("FAIL midreset_reach: got %0d plots want 100", cnt); end
        reset = 1'b0;
        @(posedge clock); #1;
        reset = 1'b1;
        checks++;
        if (plot !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL midreset_abort: got plot=%0b busy=%0b want 0 0", plot, busy);
        end
        for (int c = 0; c < 400; c++) begin
            @(posedge clock); #1;
            if (plot) extra_plot++;
            if (done) extra_done++;
        end
        checks++;
        if (extra_plot !== 0 || extra_done !== 0) begin
            errors++; $display("FAIL midreset_quiet: got %0d plots %0d done want 0 0", extra_plot, extra_done);
        end
        ext_pos = 8'd60;
        capture(-1, 1'b0, 1'b0);
        e = scan_errs(60, 1'b0);
        checks++;
        if (e !== 0 || done_at !== N + 1) begin
            errors++; $display("FAIL midreset_rescan: got %0d bad, done at %0d want 0, %0d", e, done_at, N + 1);
        end
    endtask

    task automatic test_random;
        int e, p;
        bit er;
        for (int t = 0; t < 6; t++) begin
            use_ext = 1'b1;
            ext_pos = 8'($urandom_range(0, 255));
            er = 1'($urandom);
            erase_only = er;
            p = (int'(ext_pos) >= W) ? W - 1 : int'(ext_pos);
            capture(-1, 1'b0, 1'b1);
            erase_only = 1'b0;
            e = scan_errs(p, er);
            checks++;
            if (e !== 0 || done_cnt !== 1) begin
                errors++; $display("FAIL random_%0d: pos %0d erase %0b got %0d bad, %0d done want 0, 1", t, p, er, e, done_cnt);
            end
        end
    endtask

    initial begin
        test_reset();
        test_centred();
        test_edge_clamp();
        test_keys();
        test_erase_ignore();
        test_midscan_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/paddle_drawer.md
PADDLE_DRAWER -- requirements
Module: paddle_drawer

Interface
REQ-001 SHALL have parameter SCREEN_W, default 120, meaning strip width in pixels (columns 0..SCREEN_W-1).
REQ-002 SHALL have parameter PAD_W, default 7, meaning paddle width in pixels (odd); HALF = PAD_W/2 (integer division).
REQ-003 SHALL have parameter PAD_H, default 3, meaning strip and paddle height in rows.
REQ-004 SHALL have parameter ROW_Y, default 112, meaning first row of the strip.
REQ-005 SHALL have parameter FG_COLOR, default 3'b001, meaning paddle colour.
REQ-006 SHALL have parameter BG_COLOR, default 3'b000, meaning erase colour.
REQ-007 SHALL have port clock, input, 1, meaning rising-edge clock.
REQ-008 SHALL have port reset, input, 1, meaning synchronous, active-low reset.
REQ-009 SHALL have port start, input, 1, meaning request one full strip redraw.
REQ-010 SHALL have port erase_only, input, 1, meaning sampled with start; 1 = paint whole strip BG_COLOR.
REQ-011 SHALL have port use_ext, input, 1, meaning 1 = ext_pos selects centre; 0 = internal key position.
REQ-012 SHALL have port ext_pos, input, 8, meaning external (mouse) centre column.
REQ-013 SHALL have port move_left, input, 1, meaning decrement internal position.
REQ-014 SHALL have port move_right, input, 1, meaning increment internal position.
REQ-015 SHALL have port x, output, 8, meaning pixel column.
REQ-016 SHALL have port y, output, 7, meaning pixel row.
REQ-017 SHALL have port color, output, 3, meaning pixel colour.
REQ-018 SHALL have port plot, output, 1, meaning x/y/color valid this cycle.
REQ-019 SHALL have port busy, output, 1, meaning scan in progress.
REQ-020 SHALL have port done, output, 1, meaning one-cycle pulse at scan end.
REQ-021 SHALL have port cur_pos, output, 8, meaning internal key position.

Function
REQ-022 SHALL implement states IDLE, SCAN, DONE; all outputs registered.
REQ-023 SHALL, in IDLE with start=1, latch the centre pos and erase_only, enter SCAN, and assert busy.
REQ-024 SHALL clamp the latched centre: any selected value >= SCREEN_W becomes SCREEN_W-1.
REQ-025 SHALL, in SCAN, emit one pixel per cycle with plot=1, x=col, and y=ROW_Y+row; row advances fastest (0..PAD_H-1), then col advances (0..SCREEN_W-1).
REQ-026 SHALL emit N = SCREEN_W*PAD_H pixels: with start sampled at edge k, plot=1 on cycles k+1..k+N, and done=1 on cycle k+N+1 only, after which the block returns to IDLE.
REQ-027 SHALL use color=FG_COLOR when erase_only=0 and col+HALF >= pos and col <= pos+HALF, computed in 9 bits with no underflow or wrap; otherwise color=BG_COLOR.
REQ-028 SHALL ignore start while busy or in DONE; ext_pos and use_ext changes during SCAN SHALL NOT affect the latched centre.
REQ-029 SHALL update the internal position only in IDLE with start=0: +1 on move_right, -1 on move_left, saturating at 0 and SCREEN_W-1.
REQ-030 SHALL leave the internal position unchanged when move_left and move_right are both 1.
REQ-031 SHALL drive plot=0 and done=0 in IDLE, with x, y, and color holding their last values.

Reset
REQ-032 SHALL, with reset=0 at a clock edge, set state=IDLE, x=0, y=0, color=0, plot=0, busy=0, done=0, cur_pos=(SCREEN_W-1)/2, and clear the scan counters.
REQ-033 SHALL abort a scan in progress on reset, with plot=0 from the next cycle and no done pulse.

Verification (default parameters, N=360)
REQ-034 SHALL pass the reset check: hold reset=0 for 2 cycles -> all outputs 0, cur_pos=59, busy=0.
REQ-035 SHALL pass the centred draw check: use_ext=1, ext_pos=60, start pulse -> 360 plots, 21 with color 001 at x 57..63 on y 112..114, done exactly 361 cycles after start.
REQ-036 SHALL pass the edge and clamp check: ext_pos=0 -> FG only at x 0..3, with no FG at x >= 117; ext_pos=200 -> clamped to 119, FG only at x 116..119.
REQ-037 SHALL pass the keys check: use_ext=0, move_right held 70 idle cycles -> cur_pos=119; move_left and move_right together -> unchanged; move_left during SCAN -> unchanged.
REQ-038 SHALL pass the erase and ignore check: erase_only=1 with start -> all 360 pixels color 000; a start pulse during SCAN -> no extra pixels, single done.
REQ-039 SHALL pass the mid-scan reset check: reset=0 at pixel 100 -> plot=0 next cycle, no done; a subsequent start -> full 360-pixel scan from x=0, y=112.
